pipeline_sequencer: RTL and testbench

//  Central sequencer for the 3-stage pipeline (IF/ID -> ID/EX -> EX/WB). It owns the PC

---
 rtl/pipeline_sequencer_pkg.sv | 30 +++
 rtl/pipeline_sequencer_hazard_detect.sv | 32 +++
 rtl/pipeline_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_defs
//   Shared definitions for the 3-stage pipeline sequencer: opcode constants,
//   FSM state encoding, register index width and a writeback-class decode
//   helper used by both the sequencer and the hazard decode.
// ----------------------------------------------------------------------------
package pipeline_defs;

   localparam int REG_W = 3;

   localparam logic [1:0] OP_ALU = 2'b00;
   localparam logic [1:0] OP_IMM = 2'b01;
   localparam logic [1:0] OP_JMP = 2'b10;
   localparam logic [1:0] OP_HLT = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_FLUSH  = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_HALTED = 3'd4
   } seq_state_t;

   // ALU register and ALU immediate are the only classes that write back;
   // flushed slots carry OP_HLT and therefore never do.
   function automatic logic is_writeback(input logic [1:0] op);
      return (op == OP_ALU) || (op == OP_IMM);
   endfunction

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
//   Combinational writeback / forwarding decode, shared with the datapath
//   forwarding mux.
// Ports:
//   id_opcode, exe_opcode : opcodes held in ID/EX and EX/WB
//   id_rSrc, exe_rDest    : source of the ID/EX op, destination of the EX/WB op
//   write_reg             : EX/WB result is written to the register file
//   fwd_sel               : ALU operand A must take the EX/WB result
// ----------------------------------------------------------------------------
module hazard_detect
   import pipeline_defs::*;
(
   input  logic [1:0]       id_opcode,
   input  logic [1:0]       exe_opcode,
   input  logic [REG_W-1:0] id_rSrc,
   input  logic [REG_W-1:0] exe_rDest,
   output logic             write_reg,
   output logic             fwd_sel
);

   logic wb_s;
   logic id_uses_src_s;

   assign wb_s          = is_writeback(exe_opcode);
   assign id_uses_src_s = is_writeback(id_opcode);

   // Forward only when the producer really writes and the consumer really reads a register.
   assign write_reg = wb_s;
   assign fwd_sel   = wb_s && id_uses_src_s && (exe_rDest == id_rSrc);

endmodule

// File: rtl/pipeline_sequencer.sv
// ----------------------------------------------------------------------------
// pipeline_sequencer
//   Central sequencer for the IF/ID -> ID/EX -> EX/WB pipeline. Runs an
//   IDLE/RUN/FLUSH/DRAIN/HALTED state machine that drives the PC enable, the
//   jump select and the per-stage flushes, and counts retired instructions.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   run_en                : level, leave IDLE
//   resume                : pulse, leave HALTED
//   if/id/exe_opcode      : opcodes held in the three pipeline registers
//   id_rSrc, exe_rDest    : register indices for forwarding
//   pc_en, pc_jump_sel    : PC advance / PC loads the jump target
//   if_id/id_ex/ex_wb_flush : bubble insertion per stage register
//   write_reg, fwd_sel    : register-file write enable, ALU operand A select
//   halted                : sequencer is in HALTED
//   retired               : wrapping count of writebacks
// ----------------------------------------------------------------------------
module pipeline_sequencer
   import pipeline_defs::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run_en,
   input  logic             resume,
   input  logic [1:0]       if_opcode,
   input  logic [1:0]       id_opcode,
   input  logic [1:0]       exe_opcode,
   input  logic [REG_W-1:0] id_rSrc,
   input  logic [REG_W-1:0] exe_rDest,
   output logic             pc_en,
   output logic             pc_jump_sel,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_wb_flush,
   output logic             write_reg,
   output logic             fwd_sel,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   localparam int CNT_MAX = (FLUSH_CYCLES > DRAIN_CYCLES) ? FLUSH_CYCLES : DRAIN_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0]    CNT_ONE = CW'(1'b1);
   localparam logic [CNT_W-1:0] RET_ONE = CNT_W'(1'b1);

   seq_state_t       state_r;
   logic [CW-1:0]    cnt_r;
   logic [CNT_W-1:0] retired_r;

   logic write_reg_s;
   logic fwd_sel_s;
   logic pc_en_s;
   logic pc_jump_sel_s;
   logic if_id_flush_s;
   logic id_ex_flush_s;
   logic ex_wb_flush_s;
   logic halted_s;

   hazard_detect u_hazard (
      .id_opcode  (id_opcode),
      .exe_opcode (exe_opcode),
      .id_rSrc    (id_rSrc),
      .exe_rDest  (exe_rDest),
      .write_reg  (write_reg_s),
      .fwd_sel    (fwd_sel_s)
   );

   // Sequencer state and shared flush/drain countdown.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (run_en) begin
                  state_r <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (if_opcode == OP_JMP) begin
                  // A single bubble is covered by the jump cycle itself.
                  if (FLUSH_CYCLES > 1) begin
                     state_r <= ST_FLUSH;
                     cnt_r   <= CW'(FLUSH_CYCLES - 1);
                  end
               end else if (if_opcode == OP_HLT) begin
                  state_r <= ST_DRAIN;
                  cnt_r   <= CW'(DRAIN_CYCLES);
               end
            end
            ST_FLUSH: begin
               // Wrong-path jumps/halts arriving in IF/ID are ignored here.
               cnt_r <= cnt_r - CNT_ONE;
               if (cnt_r == CNT_ONE) begin
                  state_r <= ST_RUN;
               end
            end
            ST_DRAIN: begin
               cnt_r <= cnt_r - CNT_ONE;
               if (cnt_r == CNT_ONE) begin
                  state_r <= ST_HALTED;
               end
            end
            ST_HALTED: begin
               if (resume) begin
                  state_r <= ST_RUN;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= '0;
            end
         endcase
      end
   end

   // Retired-instruction counter, wraps modulo 2^CNT_W.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         retired_r <= '0;
      end else if (write_reg_s) begin
         retired_r <= retired_r + RET_ONE;
      end else begin
         retired_r <= retired_r;
      end
   end

   // Pipeline control decode from state and the IF/ID opcode.
   always_comb begin
      pc_en_s       = 1'b0;
      pc_jump_sel_s = 1'b0;
      if_id_flush_s = 1'b0;
      id_ex_flush_s = 1'b0;
      ex_wb_flush_s = 1'b0;
      halted_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
            ex_wb_flush_s = 1'b1;
         end
         ST_RUN: begin
            pc_en_s = 1'b1;
            if (if_opcode == OP_JMP) begin
               pc_jump_sel_s = 1'b1;
               if_id_flush_s = 1'b1;
            end else if (if_opcode == OP_HLT) begin
               // HALT stays in IF/ID; ID/EX gets a bubble behind it.
               pc_en_s       = 1'b0;
               id_ex_flush_s = 1'b1;
            end else begin
               pc_jump_sel_s = 1'b0;
            end
         end
         ST_FLUSH: begin
            pc_en_s       = 1'b1;
            if_id_flush_s = 1'b1;
         end
         ST_DRAIN: begin
            id_ex_flush_s = 1'b1;
         end
         ST_HALTED: begin
            halted_s      = 1'b1;
            id_ex_flush_s = 1'b1;
            ex_wb_flush_s = 1'b1;
            // Discard the HALT so the PC resumes at the following address.
            if (resume) begin
               if_id_flush_s = 1'b1;
            end else begin
               if_id_flush_s = 1'b0;
            end
         end
         default: begin
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
            ex_wb_flush_s = 1'b1;
         end
      endcase
   end

   assign pc_en       = pc_en_s;
   assign pc_jump_sel = pc_jump_sel_s;
   assign if_id_flush = if_id_flush_s;
   assign id_ex_flush = id_ex_flush_s;
   assign ex_wb_flush = ex_wb_flush_s;
   assign write_reg   = write_reg_s;
   assign fwd_sel     = fwd_sel_s;
   assign halted      = halted_s;
   assign retired     = retired_r;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pipeline_sequencer
//   Directed self-checking bench: a table of hazard-decode vectors plus
//   hand-written sequences for reset, jump flush, halt/drain, resume and
//   counter wrap. Instance uses FLUSH_CYCLES=3, DRAIN_CYCLES=2, CNT_W=4.
// ----------------------------------------------------------------------------
module tb_pipeline_sequencer;

   localparam int CNT_W = 4;

   logic             clk;
   logic             reset;
   logic             run_en;
   logic             resume;
   logic [1:0]       if_opcode;
   logic [1:0]       id_opcode;
   logic [1:0]       exe_opcode;
   logic [2:0]       id_rSrc;
   logic [2:0]       exe_rDest;
   logic             pc_en;
   logic             pc_jump_sel;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             ex_wb_flush;
   logic             write_reg;
   logic             fwd_sel;
   logic             halted;
   logic [CNT_W-1:0] retired;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] id_op;
      logic [1:0] exe_op;
      logic [2:0] src;
      logic [2:0] dst;
      logic       exp_wr;
      logic       exp_fwd;
   } hz_vec_t;

   hz_vec_t vecs [10];

   pipeline_sequencer #(
      .FLUSH_CYCLES (3),
      .DRAIN_CYCLES (2),
      .CNT_W        (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .run_en      (run_en),
      .resume      (resume),
      .if_opcode   (if_opcode),
      .id_opcode   (id_opcode),
      .exe_opcode  (exe_opcode),
      .id_rSrc     (id_rSrc),
      .exe_rDest   (exe_rDest),
      .pc_en       (pc_en),
      .pc_jump_sel (pc_jump_sel),
      .if_id_flush (if_id_flush),
      .id_ex_flush (id_ex_flush),
      .ex_wb_flush (ex_wb_flush),
      .write_reg   (write_reg),
      .fwd_sel     (fwd_sel),
      .halted      (halted),
      .retired     (retired)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Compare the six sequencing outputs in one call.
   task automatic check_ctl(input string name, input logic e_pc, input logic e_jmp,
                            input logic e_ifl, input logic e_idl, input logic e_exl,
                            input logic e_hlt);
      check({name, ".pc_en"},       pc_en,       e_pc);
      check({name, ".pc_jump_sel"}, pc_jump_sel, e_jmp);
      check({name, ".if_id_flush"}, if_id_flush, e_ifl);
      check({name, ".id_ex_flush"}, id_ex_flush, e_idl);
      check({name, ".ex_wb_flush"}, ex_wb_flush, e_exl);
      check({name, ".halted"},      halted,      e_hlt);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{2'b01, 2'b00, 3'd3, 3'd3, 1'b1, 1'b1};
      vecs[1] = '{2'b01, 2'b00, 3'd4, 3'd3, 1'b1, 1'b0};
      vecs[2] = '{2'b00, 2'b01, 3'd5, 3'd5, 1'b1, 1'b1};
      vecs[3] = '{2'b10, 2'b00, 3'd2, 3'd2, 1'b1, 1'b0};
      vecs[4] = '{2'b11, 2'b01, 3'd2, 3'd2, 1'b1, 1'b0};
      vecs[5] = '{2'b00, 2'b10, 3'd6, 3'd6, 1'b0, 1'b0};
      vecs[6] = '{2'b00, 2'b11, 3'd6, 3'd6, 1'b0, 1'b0};
      vecs[7] = '{2'b01, 2'b00, 3'd0, 3'd0, 1'b1, 1'b1};
      vecs[8] = '{2'b00, 2'b00, 3'd7, 3'd7, 1'b1, 1'b1};
      vecs[9] = '{2'b00, 2'b00, 3'd7, 3'd6, 1'b1, 1'b0};

      reset      = 1'b0;
      run_en     = 1'b0;
      resume     = 1'b0;
      if_opcode  = 2'b00;
      id_opcode  = 2'b11;
      exe_opcode = 2'b11;
      id_rSrc    = 3'd0;
      exe_rDest  = 3'd0;
      #2;

      // Reset state
      check_ctl("reset", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      check("reset.write_reg", write_reg, 1'b0);
      check("reset.fwd_sel",   fwd_sel,   1'b0);
      check("reset.retired",   retired,   4'd0);

      // Hazard decode table, applied while reset holds the counter
      for (int i = 0; i < 10; i++) begin
         id_opcode  = vecs[i].id_op;
         exe_opcode = vecs[i].exe_op;
         id_rSrc    = vecs[i].src;
         exe_rDest  = vecs[i].dst;
         #1;
         check($sformatf("hz%0d.write_reg", i), write_reg, vecs[i].exp_wr);
         check($sformatf("hz%0d.fwd_sel", i),   fwd_sel,   vecs[i].exp_fwd);
      end
      id_opcode  = 2'b11;
      exe_opcode = 2'b11;
      tick();
      check("hz.retired_held", retired, 4'd0);

      // Reset release with run_en held: RUN after one edge
      run_en = 1'b1;
      tick();
      check_ctl("rst_low", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      reset = 1'b1;
      #1;
      check_ctl("rel_idle", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      check_ctl("rel_run", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rel.retired", retired, 4'd0);

      // Count three writebacks, then reset mid-RUN
      exe_opcode = 2'b00;
      tick(); tick(); tick();
      check("run.retired3", retired, 4'd3);
      exe_opcode = 2'b11;
      #1;
      reset = 1'b0;
      #1;
      check_ctl("mid_rst", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      check("mid_rst.retired", retired, 4'd0);
      tick();
      reset = 1'b1;
      tick();
      check_ctl("mid_rst_run", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_en = 1'b0;
      exe_opcode = 2'b00;
      tick(); tick(); tick();
      exe_opcode = 2'b11;
      check("retired3b", retired, 4'd3);

      // Jump: 3 cycles of IF/ID flush, wrong-path jump/halt ignored
      if_opcode = 2'b10;
      #1;
      check_ctl("jmp0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      if_opcode = 2'b10;
      #1;
      check_ctl("jmp1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      if_opcode = 2'b11;
      #1;
      check_ctl("jmp2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      if_opcode = 2'b00;
      #1;
      check_ctl("jmp_run", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check_ctl("jmp_run2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // HALT with two ALU ops retiring during DRAIN
      if_opcode  = 2'b11;
      id_opcode  = 2'b00;
      exe_opcode = 2'b11;
      #1;
      check_ctl("hlt_run", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      id_opcode  = 2'b11;
      exe_opcode = 2'b00;
      #1;
      check_ctl("drain1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("drain1.write_reg", write_reg, 1'b1);
      tick();
      exe_opcode = 2'b01;
      #1;
      check_ctl("drain2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      exe_opcode = 2'b11;
      #1;
      check_ctl("halted", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      check("halted.retired", retired, 4'd5);

      // run_en while HALTED is ignored
      run_en = 1'b1;
      tick();
      run_en = 1'b0;
      check_ctl("halted_runen", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

      // Resume pulse: one-cycle IF/ID flush, then RUN
      resume = 1'b1;
      #1;
      check_ctl("resume", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      resume    = 1'b0;
      if_opcode = 2'b00;
      #1;
      check_ctl("resumed", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Resume while in RUN has no effect
      resume = 1'b1;
      #1;
      check_ctl("resume_run", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      resume = 1'b0;
      check_ctl("resume_run2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Counter wrap with CNT_W=4
      reset = 1'b0;
      #1;
      check("wrap.reset", retired, 4'd0);
      tick();
      reset      = 1'b1;
      exe_opcode = 2'b00;
      for (int i = 0; i < 15; i++) tick();
      check("wrap.15", retired, 4'd15);
      tick();
      check("wrap.16", retired, 4'd0);
      tick();
      exe_opcode = 2'b11;
      check("wrap.17", retired, 4'd1);
      tick();
      check("wrap.hold", retired, 4'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
